// File: rtl/seq_checker_pkg.sv
// Shared types and constants for the counter source / pipeline / checker data path.
package seq_checker_pkg;

  localparam int DATA_WIDTH = 5;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with increment yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Checks that a stream increments by one modulo 2^WIDTH; locks, flags and counts misses,
// and drops lock after MAX_MISS consecutive misses.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int WIDTH      = DATA_WIDTH,
  parameter int LOCK_COUNT = 3,
  parameter int MAX_MISS   = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected,
  output state_t               state_dbg
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(MAX_MISS + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [XW-1:0]    miss_q, miss_d;
  logic             pulse_q, pulse_d;
  logic             hit;

  // Valid-only stream (no backpressure): a sample is consumed on every cycle with
  // in_valid=1; with in_valid=0 every register holds and no error is flagged.
  assign hit = (in_data == exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          exp_d   = in_data + WIDTH'(1);
          match_d = MW'(1);
          state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
        end
        SYNC: begin
          exp_d = in_data + WIDTH'(1);
          if (hit) begin
            match_d = match_q + MW'(1);
            if (int'(match_q) + 1 >= LOCK_COUNT) state_d = LOCKED;
          end else begin
            match_d = MW'(1);
          end
        end
        LOCKED: begin
          // Advance on a miss too, so one corrupted sample does not force a re-sync.
          exp_d = exp_q + WIDTH'(1);
          if (hit) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            if (int'(miss_q) + 1 >= MAX_MISS) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + XW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    locked    = (state_q == LOCKED);
    err_pulse = pulse_q;
    expected  = exp_q;
    state_dbg = state_q;
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pulse_d),
    .clr   (err_clr),
    .count (err_count)
  );

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: a behavioural model queues expected outputs per sample.
module tb_seq_checker;
  import seq_checker_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_data;
  logic       err_clr;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [4:0] expected;
  state_t     state_dbg;

  seq_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // {locked, err_pulse, err_count, expected}
  logic [14:0] exp_q[$];

  // reference model state
  int         m_state;
  logic [4:0] m_exp;
  int         m_match;
  int         m_miss;
  logic [7:0] m_cnt;
  logic       m_pulse;
  logic [4:0] nxt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  task automatic model_reset();
    m_state = 0; m_exp = '0; m_match = 0; m_miss = 0; m_cnt = '0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [4:0] d, input logic c);
    logic inc;
    inc = 1'b0;
    m_pulse = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        m_exp = d + 5'd1; m_match = 1; m_state = 1;
        if (m_match >= 3) m_state = 2;
      end else if (m_state == 1) begin
        if (d == m_exp) begin
          m_match++;
          if (m_match >= 3) m_state = 2;
        end else begin
          m_match = 1;
        end
        m_exp = d + 5'd1;
      end else begin
        if (d != m_exp) begin
          m_pulse = 1'b1; inc = 1'b1; m_miss++;
          if (m_miss >= 2) begin
            m_state = 0; m_miss = 0;
          end
        end else begin
          m_miss = 0;
        end
        m_exp = m_exp + 5'd1;
      end
    end
    if (c) m_cnt = inc ? 8'd1 : 8'd0;
    else if (inc && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic sb_compare();
    logic [14:0] w;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      w = exp_q.pop_front();
      check("sb_locked", {31'd0, locked}, {31'd0, w[14]});
      check("sb_err_pulse", {31'd0, err_pulse}, {31'd0, w[13]});
      check("sb_err_count", {24'd0, err_count}, {24'd0, w[12:5]});
      check("sb_expected", {27'd0, expected}, {27'd0, w[4:0]});
    end
  endtask

  // driver: apply one cycle of stimulus, queue the model's prediction, compare after the edge
  task automatic drive(input logic v, input logic [4:0] d, input logic c);
    in_valid = v; in_data = d; err_clr = c;
    model_step(v, d, c);
    exp_q.push_back({(m_state == 2), m_pulse, m_cnt, m_exp});
    @(posedge clk); #1;
    sb_compare();
  endtask

  task automatic drive_good();
    drive(1'b1, nxt, 1'b0);
    nxt = nxt + 5'd1;
  endtask

  task automatic drive_bad(input logic c);
    logic [4:0] off;
    off = 5'($urandom_range(1, 31));
    drive(1'b1, nxt + off, c);
    nxt = nxt + 5'd1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_err_pulse", {31'd0, err_pulse}, 0);
    check("rst_err_count", {24'd0, err_count}, 0);
    check("rst_expected", {27'd0, expected}, 0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, HUNT});
    rst_n = 1'b1;

    // continuous stream from 1: locks the cycle after sample 3
    nxt = 5'd1;
    drive_good(); drive_good();
    check("not_locked_yet", {31'd0, locked}, 0);
    drive_good();
    check("lock_after_3", {31'd0, locked}, 1);
    check("lock_expected_4", {27'd0, expected}, 4);
    check("lock_no_errors", {24'd0, err_count}, 0);

    // idle cycles hold everything
    repeat (3) drive(1'b0, 5'($urandom_range(0, 31)), 1'b0);
    check("idle_expected_hold", {27'd0, expected}, 4);

    while (nxt != 5'd29) drive_good();
    // wrap 29,30,31,0,1
    repeat (5) drive_good();
    check("wrap_expected_2", {27'd0, expected}, 2);
    check("wrap_locked", {31'd0, locked}, 1);
    check("wrap_no_errors", {24'd0, err_count}, 0);

    // single corruption 5,6,20,8,9
    while (nxt != 5'd7) drive_good();
    drive(1'b1, 5'd20, 1'b0); nxt = 5'd8;
    check("single_err_pulse", {31'd0, err_pulse}, 1);
    check("single_err_count", {24'd0, err_count}, 1);
    check("single_locked", {31'd0, locked}, 1);
    drive_good();
    check("single_pulse_clears", {31'd0, err_pulse}, 0);
    drive_good();
    check("single_count_stays", {24'd0, err_count}, 1);

    // two consecutive misses 5,6,20,21 drop lock
    while (nxt != 5'd7) drive_good();
    drive(1'b1, 5'd20, 1'b0);
    check("miss1_pulse", {31'd0, err_pulse}, 1);
    check("miss1_locked", {31'd0, locked}, 1);
    drive(1'b1, 5'd21, 1'b0);
    check("miss2_pulse", {31'd0, err_pulse}, 1);
    check("miss2_unlocked", {31'd0, locked}, 0);
    check("miss2_count", {24'd0, err_count}, 3);
    nxt = 5'd22;
    drive_good();
    check("rehunt_seed", {27'd0, expected}, 23);
    drive_good(); drive_good();
    check("relock", {31'd0, locked}, 1);

    // saturation: bring the count to 254 with isolated errors
    repeat (251) begin
      drive_bad(1'b0);
      drive_good();
    end
    check("sat_reach_254", {24'd0, err_count}, 254);
    drive_bad(1'b0);
    check("sat_255", {24'd0, err_count}, 255);
    drive_good();
    drive_bad(1'b0);
    check("sat_hold_255", {24'd0, err_count}, 255);
    drive_good();
    drive_bad(1'b1);
    check("clr_with_inc", {24'd0, err_count}, 1);
    drive_good();
    drive(1'b1, nxt, 1'b1); nxt = nxt + 5'd1;
    check("clr_only", {24'd0, err_count}, 0);
    check("clr_keeps_lock", {31'd0, locked}, 1);

    // asynchronous reset for part of a cycle while locked
    #2 rst_n = 1'b0; in_valid = ~in_valid;
    #1;
    check("arst_locked", {31'd0, locked}, 0);
    check("arst_err_pulse", {31'd0, err_pulse}, 0);
    check("arst_expected", {27'd0, expected}, 0);
    check("arst_state", {30'd0, state_dbg}, {30'd0, HUNT});
    in_valid = ~in_valid;
    #1 rst_n = 1'b1; in_valid = 1'b0;
    model_reset();
    nxt = 5'd10;
    drive_good(); drive_good(); drive_good();
    check("post_rst_relock", {31'd0, locked}, 1);
    check("post_rst_no_err", {24'd0, err_count}, 0);
    check("post_rst_expected", {27'd0, expected}, 13);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Receive-side checker for the 5-bit incrementing sequence produced by the counter source and carried through the two-stage register pipeline. Sits at the pipeline output and verifies that successive samples increment by exactly one, modulo 2^WIDTH. It locks onto the stream, flags and counts mismatches, and drops lock after repeated misses. It is the consumer end of that data path and serves as the on-chip integrity monitor for the pipeline.

## Interface
Parameters:
- WIDTH, 5, data width of the checked stream
- LOCK_COUNT, 3, consecutive in-sequence samples required to enter LOCKED (≥1)
- MAX_MISS, 2, consecutive mismatches in LOCKED that force return to HUNT (≥1)
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data holds a sample this cycle; tie high for the free-running source
- in_data  input  WIDTH  sample from the last pipeline stage
- err_clr  input  1  synchronous clear of err_count
- locked  output  1  checker is in LOCKED
- err_pulse  output  1  one-cycle flag for a mismatch detected in LOCKED
- err_count  output  ERR_CNT_W  saturating count of mismatches
- expected  output  WIDTH  next value the checker expects

## Operation
- States: HUNT, SYNC, LOCKED. Only cycles with in_valid=1 advance the FSM. With in_valid=0, all state holds and err_pulse=0.
- All sequence arithmetic is modulo 2^WIDTH. With WIDTH=5, 31 followed by 0 is in sequence.
- HUNT behaviour on a valid sample:
  - expected ← in_data+1 and match_cnt ← 1.
  - If LOCK_COUNT=1, go to LOCKED. Otherwise go to SYNC.
- SYNC behaviour on a valid sample:
  - If in_data==expected: match_cnt++ and expected ← in_data+1. When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - On a mismatch: re-seed with expected ← in_data+1 and match_cnt ← 1, and stay in SYNC. SYNC mismatches never count as errors.
- LOCKED behaviour on a valid sample:
  - If in_data==expected: expected ← expected+1 and miss_cnt ← 0.
  - On a mismatch:
    - err_pulse=1 for the next cycle.
    - err_count increments, saturating at 2^ERR_CNT_W−1.
    - miss_cnt++.
    - expected ← expected+1, so a single corrupted sample is tolerated without re-sync.
  - When miss_cnt reaches MAX_MISS, go to HUNT: locked drops and miss_cnt ← 0. The sample that caused the drop is still counted as an error. HUNT seeds from the next valid sample, not from the one that caused the drop.
- err_clr:
  - err_clr=1 sets err_count to 0.
  - If err_clr and an error increment occur in the same cycle, err_count becomes 1.
  - err_clr does not affect the FSM.
- Reset values: state HUNT, locked 0, err_pulse 0, err_count 0, expected 0, match_cnt 0, miss_cnt 0.
- Reset asserted mid-operation returns everything to the reset values immediately. After release, the checker re-hunts.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Compare-to-flag latency is one cycle: for a sample presented in cycle N, err_pulse and the new expected value are visible in cycle N+1.
- locked rises in the cycle after the LOCK_COUNT-th consecutive in-sequence sample has been sampled. With defaults and a continuous stream, this is 3 cycles after the first valid sample.
- locked falls in the cycle after the MAX_MISS-th consecutive mismatch. err_pulse is 1 in that same cycle.
- Back-to-back mismatches produce err_pulse high on consecutive cycles, with no forced gap.

## Structure
- Shared package:
  - state enum typedef {HUNT, SYNC, LOCKED}
  - default DATA_WIDTH=5 constant shared with the source and the pipeline registers
- Natural sub-module: sat_counter (parameter width; inputs inc and clr; clr with inc yields 1), used for err_count.
- match_cnt and miss_cnt are sized $clog2(LOCK_COUNT+1) and $clog2(MAX_MISS+1) respectively.

## Test plan
- Reset, then continuous stream 1,2,3,4… with in_valid=1 → locked=1 in the cycle after sample 3 is sampled, err_count=0, expected=4 at that point.
- Locked stream 29,30,31,0,1 → no err_pulse and locked stays 1 across the wrap; expected=2 after the last sample.
- Locked stream 5,6,X=20,8,9 → a single err_pulse one cycle after 20, err_count=1, locked stays 1, no further errors.
- Locked stream 5,6,20,21 (MAX_MISS=2) → err_pulse on two consecutive cycles, err_count=2, locked=0 after the second. Then stream 22,23,24 → locked=1 again.
- Force err_count to 254 and inject 3 errors, with err_clr pulsed on the third → err_count reads 255 after the second error and 1 after the third.
- Assert rst_n=0 mid-LOCKED, for part of a cycle, with in_valid toggling → all outputs return to reset values immediately. After release, stream 10,11,12 relocks with no errors counted.
